mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single main-memory port between the instruction cache and the data cache miss paths. It accepts line-refill (read) and write-back (write) requests from both caches and grants one requester at a time. It forwards the chosen request and its write-data beats to memory, then routes read-response beats back to the owner. Between the memory port and the two caches, it is the only block that sequences main-memory traffic.

## Interface
- ADDR_W, 28: line-granular memory address width
- DATA_W, 128: width of one memory data beat
- BEATS, 4: beats per cache line, ≥1; the beat counter is ceil(log2(BEATS+1)) bits
- clk  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- ic_req_valid  in  1  icache requests a line read
- ic_req_ready  out  1  icache request accepted this cycle
- ic_req_addr  in  ADDR_W  icache line address
- ic_resp_valid  out  1  read beat for icache on mem_resp_data
- dc_req_valid  in  1  dcache request
- dc_req_ready  out  1  dcache request accepted this cycle
- dc_req_rw  in  1  0 = line read, 1 = line write
- dc_req_addr  in  ADDR_W  dcache line address
- dc_wdata_valid  in  1  dcache write beat valid
- dc_wdata_ready  out  1  write beat accepted
- dc_wdata  in  DATA_W  write beat data
- dc_resp_valid  out  1  read beat for dcache on mem_resp_data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  forwarded rw
- mem_req_addr  out  ADDR_W  forwarded address
- mem_wdata_valid  out  1  write beat to memory
- mem_wdata_ready  in  1  memory accepts write beat
- mem_wdata  out  DATA_W  = dc_wdata, passthrough
- mem_resp_valid  in  1  read beat from memory
- mem_resp_data  in  DATA_W  read data, fanned out to both caches

## Operation
- States: IDLE, REQ, WDATA, RDATA.
- Owner register `own` (0 = icache, 1 = dcache) and `last` register (owner of the previous grant).
- IDLE:
  - If only one requester has valid high, grant it.
  - If both are valid, grant the dcache unless `last` == dcache, in which case grant the icache. This alternates under contention, so neither starves.
  - On grant: latch own, rw (icache forces rw = 0) and addr; set `last` = own; go to REQ.
- REQ:
  - mem_req_valid = 1; mem_req_rw and mem_req_addr come from the latched registers.
  - Owner's req_ready = mem_req_ready (combinational). The non-owner's ready = 0.
  - On mem_req_ready: go to WDATA if rw = 1, else go to RDATA. Clear the beat counter.
- WDATA (dcache only):
  - mem_wdata_valid = dc_wdata_valid; dc_wdata_ready = mem_wdata_ready.
  - Each cycle both are high, increment the counter.
  - On the BEATS-th beat, go to IDLE.
- RDATA:
  - Owner's resp_valid = mem_resp_valid; the other's resp_valid = 0.
  - Count beats; on the BEATS-th beat, go to IDLE.
  - mem_resp_valid in any state other than RDATA is ignored and not routed.
- A requester must hold valid and addr stable until its ready. The arbiter reads only the latched copies after the grant.
- A requester's valid dropping after the grant does not abort the transaction.

## Timing
- Reset: state = IDLE, own = 0, `last` = icache, counter = 0.
- All valid/ready outputs are 0 in IDLE and during reset. mem_req_addr and mem_req_rw are 0 in IDLE.
- Grant latency: request valid at edge N means IDLE→REQ at N. mem_req_valid is high in cycle N+1 at the earliest.
- Request handshake completes in the same cycle as mem_req_ready; the requester sees ready in that cycle.
- After the last beat, the FSM is in IDLE for at least one cycle before the next grant (one-cycle turnaround, no back-to-back grant).
- Read completion: the last beat counted at edge M moves the FSM to IDLE at M. A new request can issue at M+2.
- Reset asserted in any state returns to IDLE on the next edge. Any partial burst is abandoned and no further ready/resp is issued for it.
- A beat counter reaching BEATS and mem_resp_valid in the same cycle is the terminating beat; no extra beat is forwarded.

## Test plan
- Icache only, addr 0x0000123, BEATS = 4, memory ready after 2 cycles, then 4 beats with 1-cycle gaps → ic_req_ready pulses once; ic_resp_valid pulses exactly 4 times; dc_resp_valid is never high; back in IDLE afterward.
- Dcache write, addr 0x00ABCDE, dc_wdata beats 0x1..0x4 with mem_wdata_ready stalled every other cycle → mem_wdata shows 0x1, 0x2, 0x3, 0x4 in order; exactly 4 handshakes; no resp routing.
- Both valid continuously for 4 transactions from reset (`last` = icache) → grant order dc, ic, dc, ic.
- Icache-only request from reset while dcache idle → icache granted; a dcache request that arrives mid-burst waits until IDLE, then is granted.
- Reset asserted after the 2nd of 4 read beats → next cycle is IDLE with all outputs 0; the remaining memory beats do not assert ic_resp_valid or dc_resp_valid.
- Spurious mem_resp_valid in IDLE and REQ → no resp_valid to either cache; the counter stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose: shares one main-memory port between the icache and dcache miss paths.
// Latency: grant registered in IDLE, request on the port one cycle later; one idle turnaround cycle after each burst.
// Backpressure: mem_req_ready / mem_wdata_ready stall the owner combinationally; the non-owner sees no ready.
//
// Ports:
//   clk, reset                     - single clock, synchronous active-high reset
//   ic_req_valid/ready/addr        - icache line-read request
//   ic_resp_valid                  - icache read beat present on mem_resp_data
//   dc_req_valid/ready/rw/addr     - dcache line read (rw=0) or write-back (rw=1) request
//   dc_wdata_valid/ready, dc_wdata - dcache write beats
//   dc_resp_valid                  - dcache read beat present on mem_resp_data
//   mem_req_valid/ready/rw/addr    - request forwarded to memory
//   mem_wdata_valid/ready, mem_wdata - write beats forwarded to memory
//   mem_resp_valid, mem_resp_data  - read beats from memory, fanned out to both caches
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_wdata_valid,
  output logic              dc_wdata_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_resp_valid,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

  state_t            state, state_nxt;
  logic              own;      // 0 = icache, 1 = dcache
  logic              last;     // owner of the previous grant
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt;

  logic grant, grant_dc, beat, last_beat;

  // Under contention the dcache wins unless it also won last time.
  assign grant    = ic_req_valid | dc_req_valid;
  assign grant_dc = dc_req_valid & (~ic_req_valid | ~last);

  // Read data is fanned out untouched; only the valids are routed.
  assign mem_wdata = dc_wdata;
  assign last_beat = beat & (cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    beat            = 1'b0;
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    ic_resp_valid   = 1'b0;
    dc_resp_valid   = 1'b0;
    dc_wdata_ready  = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_rw      = 1'b0;
    mem_req_addr    = '0;
    mem_wdata_valid = 1'b0;

    case (state)
      IDLE: begin
        if (grant) state_nxt = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = rw_q;
        mem_req_addr  = addr_q;
        ic_req_ready  = ~own & mem_req_ready;
        dc_req_ready  = own & mem_req_ready;
        if (mem_req_ready) state_nxt = rw_q ? WDATA : RDATA;
      end
      WDATA: begin
        mem_wdata_valid = dc_wdata_valid;
        dc_wdata_ready  = mem_wdata_ready;
        beat            = dc_wdata_valid & mem_wdata_ready;
        if (last_beat) state_nxt = IDLE;
      end
      RDATA: begin
        ic_resp_valid = ~own & mem_resp_valid;
        dc_resp_valid = own & mem_resp_valid;
        beat          = mem_resp_valid;
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // While reset is held the current burst is dead: nothing may handshake,
    // even though the state register only clears at the next edge.
    if (reset) begin
      beat            = 1'b0;
      ic_req_ready    = 1'b0;
      dc_req_ready    = 1'b0;
      ic_resp_valid   = 1'b0;
      dc_resp_valid   = 1'b0;
      dc_wdata_ready  = 1'b0;
      mem_req_valid   = 1'b0;
      mem_req_rw      = 1'b0;
      mem_req_addr    = '0;
      mem_wdata_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own    <= 1'b0;
      last   <= 1'b0;
      rw_q   <= 1'b0;
      addr_q <= '0;
      cnt    <= '0;
    end else begin
      if (state == IDLE && grant) begin
        own    <= grant_dc;
        last   <= grant_dc;
        rw_q   <= grant_dc & dc_req_rw;   // icache only ever reads
        addr_q <= grant_dc ? dc_req_addr : ic_req_addr;
      end
      // Counter is zero whenever a burst is not in flight.
      if (state == REQ && mem_req_ready) begin
        cnt <= '0;
      end else if (beat) begin
        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int BEATS  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              dc_req_valid, dc_req_ready, dc_req_rw, dc_resp_valid;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_wdata_valid, dc_wdata_ready;
  logic [DATA_W-1:0] dc_wdata;
  logic              mem_req_valid, mem_req_ready, mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_wdata_valid, mem_wdata_ready;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr),
    .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready), .dc_wdata(dc_wdata),
    .dc_resp_valid(dc_resp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: who won last, and what each cache is asking for.
  bit                m_last;
  bit                ic_pend, dc_pend, dc_rw_h;
  logic [ADDR_W-1:0] ic_addr_h, dc_addr_h;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    ic_req_valid = ic_pend;
    ic_req_addr  = ic_addr_h;
    dc_req_valid = dc_pend;
    dc_req_rw    = dc_rw_h;
    dc_req_addr  = dc_addr_h;
  endtask

  // Memory side shouting everything at once: the arbiter must ignore it
  // unless it is in the matching phase.
  task automatic spurious_mem();
    mem_req_ready   = 1'b1;
    mem_wdata_ready = 1'b1;
    mem_resp_valid  = 1'b1;
    mem_resp_data   = rand_data();
    dc_wdata_valid  = 1'b1;
  endtask

  task automatic chk_quiet(input string tag, input bit with_addr);
    chk({tag, "_valids"}, {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid,
                          mem_req_valid, mem_wdata_valid, dc_wdata_ready}, '0);
    if (with_addr) chk({tag, "_addr_rw"}, {mem_req_rw, mem_req_addr}, '0);
  endtask

  task automatic raise_ic();
    ic_pend   = 1'b1;
    ic_addr_h = ADDR_W'($urandom());
  endtask

  task automatic raise_dc();
    dc_pend   = 1'b1;
    dc_rw_h   = 1'($urandom() % 2);
    dc_addr_h = ADDR_W'($urandom());
  endtask

  // Starts and ends just after a posedge.
  task automatic do_reset();
    reset   = 1'b1;
    ic_pend = 1'b0;
    dc_pend = 1'b0;
    drive_reqs();
    spurious_mem();
    @(negedge clk);
    chk_quiet("in_reset", 1'b0);
    next_cycle();
    reset  = 1'b0;
    m_last = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset", 1'b1);
    next_cycle();
  endtask

  // One whole transaction from an idle arbiter: idle cycle, request phase
  // (memory ready after req_wait cycles), then BEATS data beats.
  task automatic do_txn(input int req_wait, input bit alt, input int gap_pct,
                        input bit fixed_data, input bit raise_other, input int abort_at);
    bit                own, rw, v, r, rv;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd [BEATS];
    int                i, cyc;

    own    = (ic_pend && dc_pend) ? ~m_last : dc_pend;
    rw     = own ? dc_rw_h : 1'b0;
    addr   = own ? dc_addr_h : ic_addr_h;
    m_last = own;
    for (int k = 0; k < BEATS; k++) wd[k] = fixed_data ? DATA_W'(k + 1) : rand_data();

    drive_reqs();
    spurious_mem();
    @(negedge clk);
    chk_quiet("idle", 1'b1);
    next_cycle();

    for (int w = 0; w <= req_wait; w++) begin
      drive_reqs();
      mem_req_ready   = (w == req_wait);
      mem_resp_valid  = 1'b1;
      mem_wdata_ready = 1'b1;
      dc_wdata_valid  = 1'b1;
      @(negedge clk);
      chk("req_valid", mem_req_valid, 1'b1);
      chk("req_addr_rw", {mem_req_rw, mem_req_addr}, {rw, addr});
      chk("ic_req_ready", ic_req_ready, !own && (w == req_wait));
      chk("dc_req_ready", dc_req_ready, own && (w == req_wait));
      chk("req_no_data", {ic_resp_valid, dc_resp_valid, mem_wdata_valid, dc_wdata_ready}, '0);
      next_cycle();
    end

    if (own) dc_pend = 1'b0; else ic_pend = 1'b0;
    if (raise_other) begin
      if (own) raise_ic(); else raise_dc();
    end
    drive_reqs();

    i   = 0;
    cyc = 0;
    while (i < BEATS && cyc < 200) begin
      if (i == abort_at) begin
        reset   = 1'b1;
        ic_pend = 1'b0;
        dc_pend = 1'b0;
        drive_reqs();
        spurious_mem();
        @(negedge clk);
        chk_quiet("abort_in_reset", 1'b0);
        next_cycle();
        reset  = 1'b0;
        m_last = 1'b0;
        for (int t = 0; t < 3; t++) begin
          spurious_mem();
          @(negedge clk);
          chk_quiet("abort_after", 1'b1);
          next_cycle();
        end
        return;
      end
      if (rw) begin
        v = alt ? 1'b1 : ($urandom_range(0, 99) >= gap_pct);
        r = alt ? (cyc % 2 == 1) : ($urandom_range(0, 99) >= gap_pct);
        dc_wdata_valid  = v;
        dc_wdata        = wd[i];
        mem_wdata_ready = r;
        mem_resp_valid  = 1'($urandom() % 2);
        mem_req_ready   = 1'($urandom() % 2);
        @(negedge clk);
        chk("wd_valid", mem_wdata_valid, v);
        chk("wd_ready", dc_wdata_ready, r);
        chk("wd_data", mem_wdata, wd[i]);
        chk("wd_quiet", {ic_resp_valid, dc_resp_valid, mem_req_valid, ic_req_ready, dc_req_ready}, '0);
        if (v && r) i++;
      end else begin
        rv = alt ? (cyc % 2 == 1) : ($urandom_range(0, 99) >= gap_pct);
        mem_resp_valid  = rv;
        mem_resp_data   = rand_data();
        dc_wdata_valid  = 1'b1;
        mem_wdata_ready = 1'b1;
        mem_req_ready   = 1'($urandom() % 2);
        @(negedge clk);
        chk("rd_ic", ic_resp_valid, rv && !own);
        chk("rd_dc", dc_resp_valid, rv && own);
        chk("rd_quiet", {mem_wdata_valid, dc_wdata_ready, mem_req_valid, ic_req_ready, dc_req_ready}, '0);
        if (rv) i++;
      end
      cyc++;
      next_cycle();
    end
    if (i < BEATS) chk("burst_timeout", DATA_W'(i), DATA_W'(BEATS));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    ic_pend         = 1'b0;
    dc_pend         = 1'b0;
    dc_rw_h         = 1'b0;
    ic_addr_h       = '0;
    dc_addr_h       = '0;
    m_last          = 1'b0;
    dc_wdata        = '0;
    dc_wdata_valid  = 1'b0;
    mem_req_ready   = 1'b0;
    mem_wdata_ready = 1'b0;
    mem_resp_valid  = 1'b0;
    mem_resp_data   = '0;
    drive_reqs();
    next_cycle();
    do_reset();

    // Icache line read: memory ready after 2 cycles, beats with 1-cycle gaps.
    ic_pend   = 1'b1;
    ic_addr_h = 28'h0000123;
    do_txn(2, 1'b1, 0, 1'b0, 1'b0, -1);

    // Dcache write-back, beats 1..4, memory stalls every other cycle.
    dc_pend   = 1'b1;
    dc_rw_h   = 1'b1;
    dc_addr_h = 28'h00ABCDE;
    do_txn(0, 1'b1, 0, 1'b1, 1'b0, -1);

    // Both requesting continuously from reset: must alternate dc, ic, dc, ic.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      if (!ic_pend) raise_ic();
      if (!dc_pend) raise_dc();
      do_txn($urandom_range(0, 2), 1'b0, 30, 1'b0, 1'b0, -1);
    end

    // Icache alone from reset; dcache shows up mid-burst and waits its turn.
    do_reset();
    raise_ic();
    do_txn(1, 1'b0, 30, 1'b0, 1'b1, -1);
    do_txn(0, 1'b0, 30, 1'b0, 1'b0, -1);

    // Reset after the 2nd of 4 read beats abandons the burst.
    do_reset();
    raise_ic();
    do_txn(1, 1'b0, 0, 1'b0, 1'b0, 2);

    // Randomized traffic.
    for (int n = 0; n < 25; n++) begin
      if (!ic_pend && ($urandom() % 2 == 1)) raise_ic();
      if (!dc_pend && (($urandom() % 2 == 1) || !ic_pend)) raise_dc();
      do_txn($urandom_range(0, 3), 1'b0, 40, 1'b0, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
